// File: rtl/apb_mem_pkg.sv
// Shared types and default widths for the APB word-memory completer.
package apb_mem_pkg;

  localparam int unsigned APB_DATA_WIDTH  = 32;
  localparam int unsigned APB_ADDR_WIDTH  = 10;
  localparam int unsigned APB_NUM_REGIONS = 8;
  localparam int unsigned APB_STRB_WIDTH  = APB_DATA_WIDTH / 8;
  localparam int unsigned BYTE_IDX_W      = $clog2(APB_STRB_WIDTH);
  localparam int unsigned WORD_IDX_W      = APB_ADDR_WIDTH - BYTE_IDX_W;
  localparam int unsigned REGION_IDX_W    = $clog2(APB_NUM_REGIONS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic unaligned;
    logic priv_fail;
    logic sec_fail;
    logic strb_fail;
  } chk_t;

endpackage

// File: rtl/apb_mem_completer_v2_if.sv
// APB4 completer-side bus bundle (requester drives, completer responds).
interface apb_mem_completer_v2_if
  import apb_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  PSELx;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [2:0]            PPROT;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [STRB_WIDTH-1:0] PSTRB;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PPROT, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PPROT, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_access_check.sv
// Combinational alignment, region privilege/security and read-strobe checks.
module apb_access_check
  import apb_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int unsigned STRB_WIDTH  = APB_STRB_WIDTH,
  parameter int unsigned NUM_REGIONS = APB_NUM_REGIONS,
  parameter int unsigned BYTE_W      = BYTE_IDX_W,
  parameter int unsigned WORD_W      = WORD_IDX_W,
  parameter int unsigned REGION_W    = REGION_IDX_W,
  parameter logic [NUM_REGIONS-1:0] PRIV_MASK   = NUM_REGIONS'(8'hF0),
  parameter logic [NUM_REGIONS-1:0] SECURE_MASK = NUM_REGIONS'(8'h80)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            prot,
  input  logic                  write,
  input  logic [STRB_WIDTH-1:0] strb,
  output chk_t                  chk_c,
  output logic [WORD_W-1:0]     word_idx_c
);
  logic [REGION_W-1:0] region_c;
  logic                unused_prot;

  assign word_idx_c  = WORD_W'(addr >> BYTE_W);
  assign region_c    = word_idx_c[WORD_W-1 -: REGION_W];
  // Instruction/data bit carries no meaning for this memory.
  assign unused_prot = prot[2];

  always_comb begin
    chk_c           = '0;
    chk_c.unaligned = (addr & ADDR_WIDTH'(STRB_WIDTH - 1)) != '0;
    chk_c.priv_fail = PRIV_MASK[region_c] && !prot[0];
    chk_c.sec_fail  = SECURE_MASK[region_c] && prot[1];
    chk_c.strb_fail = !write && (strb != '0);
  end
endmodule

// File: rtl/apb_mem_completer_v2.sv
// APB4 leaf completer: byte-strobed word memory, programmable wait states,
// per-region protection checks and a saturating error counter.
module apb_mem_completer_v2
  import apb_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int unsigned NUM_REGIONS = APB_NUM_REGIONS,
  parameter logic [NUM_REGIONS-1:0] PRIV_MASK   = NUM_REGIONS'(8'hF0),
  parameter logic [NUM_REGIONS-1:0] SECURE_MASK = NUM_REGIONS'(8'h80)
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  apb_mem_completer_v2_if.slave        apb,
  input  logic [3:0]                   cfg_wait,
  output logic [15:0]                  err_count
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned BYTE_W     = $clog2(STRB_WIDTH);
  localparam int unsigned WORD_W     = ADDR_WIDTH - BYTE_W;
  localparam int unsigned REGION_W   = $clog2(NUM_REGIONS);
  localparam int unsigned DEPTH      = 1 << WORD_W;

  apb_state_e            state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;
  logic [WORD_W-1:0]     widx_q, widx_d;
  logic [15:0]           err_count_q, err_count_d;
  logic                  mem_we_c;
  chk_t                  chk_c;
  logic [WORD_W-1:0]     widx_c;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Checks run on the live bus; the result is latched at SETUP->ACCESS.
  apb_access_check #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STRB_WIDTH  (STRB_WIDTH),
    .NUM_REGIONS (NUM_REGIONS),
    .BYTE_W      (BYTE_W),
    .WORD_W      (WORD_W),
    .REGION_W    (REGION_W),
    .PRIV_MASK   (PRIV_MASK),
    .SECURE_MASK (SECURE_MASK)
  ) u_check (
    .addr       (apb.PADDR),
    .prot       (apb.PPROT),
    .write      (apb.PWRITE),
    .strb       (apb.PSTRB),
    .chk_c      (chk_c),
    .word_idx_c (widx_c)
  );

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    prdata_d    = '0;
    write_d     = write_q;
    err_d       = err_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    strb_d      = strb_q;
    widx_d      = widx_q;
    err_count_d = err_count_q;
    mem_we_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (apb.PSELx && !apb.PENABLE) state_d = SETUP;
      end
      SETUP: begin
        if (apb.PSELx && apb.PENABLE) begin
          state_d = ACCESS;
          write_d = apb.PWRITE;
          wdata_d = apb.PWDATA;
          strb_d  = apb.PSTRB;
          widx_d  = widx_c;
          err_d   = |chk_c;
          wcnt_d  = cfg_wait;
          rdata_d = (|chk_c || apb.PWRITE) ? '0 : mem_q[widx_c];
          if (cfg_wait == 4'd0) begin
            pready_d  = 1'b1;
            pslverr_d = |chk_c;
            prdata_d  = rdata_d;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (pready_q) begin
          mem_we_c = write_q && !err_q;
          if (err_q && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'd1;
          state_d = (apb.PSELx && !apb.PENABLE) ? SETUP : IDLE;
        end else if (!apb.PSELx || !apb.PENABLE) begin
          state_d = IDLE;
        end else begin
          // wcnt_q is at least 1 here: a zero load completes immediately.
          wcnt_d = wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
            prdata_d  = rdata_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      prdata_q    <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      strb_q      <= '0;
      widx_q      <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      prdata_q    <= prdata_d;
      write_q     <= write_d;
      err_q       <= err_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      strb_q      <= strb_d;
      widx_q      <= widx_d;
      err_count_q <= err_count_d;
    end
  end

  // Word storage; byte lanes committed on the completing edge.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we_c) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (strb_q[b]) mem_q[widx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;
  assign apb.PRDATA  = prdata_q;
  assign err_count   = err_count_q;
endmodule

// File: tb/tb_apb_mem_completer_v2.sv
// Table-driven bench for apb_mem_completer_v2 with a response scoreboard.
module tb_apb_mem_completer_v2;
  import apb_mem_pkg::*;

  localparam int unsigned DW = APB_DATA_WIDTH;
  localparam int unsigned AW = APB_ADDR_WIDTH;
  localparam int unsigned SW = DW / 8;
  localparam int          NV = 24;

  typedef struct {
    bit          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
    int unsigned   wt;
    logic [DW-1:0] exp_rdata;
    bit            exp_err;
    logic [15:0]   exp_cnt;
  } vec_t;

  typedef struct {
    logic [DW-1:0] rdata;
    bit            err;
    logic [15:0]   cnt;
  } exp_t;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [3:0]  cfg_wait;
  logic [15:0] err_count;

  vec_t tbl [NV];
  exp_t sb_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   cnt_pend = 1'b0;
  logic [15:0] pend_cnt = '0;

  apb_mem_completer_v2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_mem_completer_v2 #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .NUM_REGIONS (8),
    .PRIV_MASK   (8'hF0),
    .SECURE_MASK (8'h80)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .apb       (bus.slave),
    .cfg_wait  (cfg_wait),
    .err_count (err_count)
  );

  always #5 PCLK = ~PCLK;

  function automatic vec_t mk(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input logic [SW-1:0] strb, input logic [2:0] prot, input int unsigned wt,
                              input logic [DW-1:0] exp_rdata, input bit exp_err, input logic [15:0] exp_cnt);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.prot = prot; v.wt = wt;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_cnt = exp_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    bus.PSELx = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0; bus.PWDATA = '0; bus.PSTRB = '0; bus.PPROT = '0;
  endtask

  task automatic drive_setup(input vec_t v);
    bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = v.wr;
    bus.PADDR = v.addr; bus.PWDATA = v.wdata; bus.PSTRB = v.strb; bus.PPROT = v.prot;
    cfg_wait = 4'(v.wt);
  endtask

  // Wiggle everything except the handshake while waiting; latched values must win.
  task automatic scramble();
    bus.PADDR  = AW'($urandom);
    bus.PWDATA = DW'($urandom);
    bus.PSTRB  = SW'($urandom);
    bus.PPROT  = 3'($urandom);
    bus.PWRITE = 1'($urandom);
    cfg_wait   = 4'($urandom);
  endtask

  // Called one cycle before the FSM enters SETUP; finishes the transfer and
  // drives the next SETUP (or idles) inside the PREADY cycle.
  task automatic finish_xfer(input int idx, input bit has_next);
    vec_t v;
    exp_t e;
    int   n;
    v = tbl[idx];
    n = 0;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.cnt = v.exp_cnt;
    sb_q.push_back(e);
    while (n < 40) begin
      @(posedge PCLK); #1;
      n++;
      if (bus.PREADY === 1'b1) break;
      scramble();
    end
    check($sformatf("latency[%0d]", idx), 32'(n), 32'(v.wt + 1));
    if (has_next) drive_setup(tbl[idx + 1]);
    else idle_bus();
  endtask

  task automatic run_table(input int lo, input int hi);
    @(posedge PCLK); #1;
    drive_setup(tbl[lo]);
    for (int i = lo; i <= hi; i++) finish_xfer(i, i < hi);
  endtask

  task automatic mon_step();
    exp_t e;
    if (cnt_pend) begin
      check("err_count", 32'(err_count), 32'(pend_cnt));
      cnt_pend = 1'b0;
    end
    if (bus.PREADY === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_pready", 32'(bus.PREADY), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("prdata", bus.PRDATA, e.rdata);
        check("pslverr", 32'(bus.PSLVERR), 32'(e.err));
        pend_cnt = e.cnt;
        cnt_pend = 1'b1;
      end
    end else begin
      check("idle_outputs", bus.PRDATA | 32'(bus.PSLVERR), 32'd0);
    end
  endtask

  initial begin
    tbl[0]  = mk(1, 10'h004, 32'hDEADBEEF, 4'hF, 3'b000, 0,  32'h0,        0, 16'd0);
    tbl[1]  = mk(0, 10'h004, 32'h0,        4'h0, 3'b000, 0,  32'hDEADBEEF, 0, 16'd0);
    tbl[2]  = mk(1, 10'h008, 32'h11223344, 4'h5, 3'b000, 3,  32'h0,        0, 16'd0);
    tbl[3]  = mk(0, 10'h008, 32'h0,        4'h0, 3'b000, 1,  32'h00220044, 0, 16'd0);
    tbl[4]  = mk(1, 10'h200, 32'hAAAA5555, 4'hF, 3'b000, 0,  32'h0,        1, 16'd1);
    tbl[5]  = mk(0, 10'h200, 32'h0,        4'h0, 3'b001, 0,  32'h0,        0, 16'd1);
    tbl[6]  = mk(1, 10'h200, 32'h12345678, 4'hF, 3'b001, 2,  32'h0,        0, 16'd1);
    tbl[7]  = mk(0, 10'h200, 32'h0,        4'h0, 3'b001, 0,  32'h12345678, 0, 16'd1);
    tbl[8]  = mk(0, 10'h3FC, 32'h0,        4'h0, 3'b011, 0,  32'h0,        1, 16'd2);
    tbl[9]  = mk(0, 10'h006, 32'h0,        4'h0, 3'b000, 0,  32'h0,        1, 16'd3);
    tbl[10] = mk(0, 10'h004, 32'h0,        4'h1, 3'b000, 0,  32'h0,        1, 16'd4);
    tbl[11] = mk(1, 10'h3FC, 32'hCAFEF00D, 4'hF, 3'b001, 1,  32'h0,        0, 16'd4);
    tbl[12] = mk(0, 10'h3FC, 32'h0,        4'h0, 3'b101, 0,  32'hCAFEF00D, 0, 16'd4);
    tbl[13] = mk(1, 10'h00C, 32'h55555555, 4'h0, 3'b000, 0,  32'h0,        0, 16'd4);
    tbl[14] = mk(0, 10'h00C, 32'h0,        4'h0, 3'b000, 15, 32'h0,        0, 16'd4);
    tbl[15] = mk(1, 10'h010, 32'h01020304, 4'hF, 3'b000, 0,  32'h0,        0, 16'd4);
    tbl[16] = mk(0, 10'h3FC, 32'h0,        4'h0, 3'b000, 0,  32'h0,        1, 16'd5);
    tbl[17] = mk(1, 10'h3FC, 32'hFFFFFFFF, 4'hF, 3'b010, 0,  32'h0,        1, 16'd6);
    tbl[18] = mk(0, 10'h3FC, 32'h0,        4'h0, 3'b001, 0,  32'hCAFEF00D, 0, 16'd6);
    tbl[19] = mk(0, 10'h010, 32'h0,        4'h0, 3'b000, 0,  32'h01020304, 0, 16'd6);
    tbl[20] = mk(0, 10'h020, 32'h0,        4'h0, 3'b000, 0,  32'h0,        0, 16'd0);
    tbl[21] = mk(1, 10'h020, 32'hA5A5A5A5, 4'hF, 3'b000, 0,  32'h0,        0, 16'd0);
    tbl[22] = mk(0, 10'h020, 32'h0,        4'h0, 3'b000, 2,  32'hA5A5A5A5, 0, 16'd0);
    tbl[23] = mk(0, 10'h004, 32'h0,        4'h0, 3'b001, 0,  32'h0,        0, 16'd0);

    idle_bus();
    cfg_wait = 4'd0;
    fork
      forever begin
        @(negedge PCLK);
        mon_step();
      end
    join_none

    repeat (3) @(posedge PCLK);
    #1;
    check("reset_pready", 32'(bus.PREADY), 32'd0);
    check("reset_prdata", bus.PRDATA, 32'd0);
    check("reset_pslverr", 32'(bus.PSLVERR), 32'd0);
    check("reset_err_count", 32'(err_count), 32'd0);
    PRESETn = 1'b1;

    run_table(0, 18);
    repeat (3) @(posedge PCLK);

    // Abort: PENABLE drops in the 2nd ACCESS cycle of a 5-wait write.
    #1;
    drive_setup(mk(1, 10'h010, 32'hFFFFFFFF, 4'hF, 3'b000, 5, 32'h0, 0, 16'd0));
    @(posedge PCLK); #1; bus.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    check("abort_pready", 32'(bus.PREADY), 32'd0);
    bus.PENABLE = 1'b0;
    @(posedge PCLK); #1;
    idle_bus();
    repeat (4) @(posedge PCLK);
    #1;
    check("abort_err_count", 32'(err_count), 32'd6);
    run_table(19, 19);
    repeat (3) @(posedge PCLK);

    // Reset during the wait states of a write.
    #1;
    drive_setup(mk(1, 10'h020, 32'h77777777, 4'hF, 3'b000, 4, 32'h0, 0, 16'd0));
    @(posedge PCLK); #1; bus.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    #1;
    check("rst_mid_pready", 32'(bus.PREADY), 32'd0);
    check("rst_mid_prdata", bus.PRDATA, 32'd0);
    check("rst_mid_pslverr", 32'(bus.PSLVERR), 32'd0);
    check("rst_mid_err_count", 32'(err_count), 32'd0);
    idle_bus();
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    run_table(20, 23);
    repeat (3) @(posedge PCLK);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_mem_completer_v2.md
Name: apb_mem_completer_v2

Overview:
Parametrised APB4 completer fronting a byte-strobed word memory that is split into equal protection regions. Replaces the externally driven ready input with an internal programmable wait-state counter. Adds per-region privileged and secure access checks, strict alignment and strobe checking, abort on protocol violation, and a saturating error counter for debug. Sits on the APB segment as a leaf completer behind the bridge.

Parameters:
DATA_WIDTH, 32, PWDATA/PRDATA width; multiple of 8, range 8..64
ADDR_WIDTH, 10, byte address width
STRB_WIDTH, DATA_WIDTH/8, byte lanes (derived)
DEPTH, 2**(ADDR_WIDTH-log2(STRB_WIDTH)), number of memory words (derived)
NUM_REGIONS, 8, protection regions; power of 2, no larger than DEPTH
PRIV_MASK, 8'hF0, bit r set: region r requires PPROT[0]=1
SECURE_MASK, 8'h80, bit r set: region r requires PPROT[1]=0

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous active-low reset
PSELx  in  1  completer select
PENABLE  in  1  access phase
PWRITE  in  1  1 = write
PADDR  in  ADDR_WIDTH  byte address
PPROT  in  3  protection type
PWDATA  in  DATA_WIDTH  write data
PSTRB  in  STRB_WIDTH  write byte strobes
cfg_wait  in  4  wait states per transfer, 0..15
PREADY  out  1  transfer complete
PRDATA  out  DATA_WIDTH  read data
PSLVERR  out  1  error response, valid only while PREADY=1
err_count  out  16  saturating count of errored transfers

Behaviour:
- Clock and reset: one clock, PCLK; reset PRESETn is asynchronous, active-low.
- Reset values: state=IDLE; PREADY=0; PSLVERR=0; PRDATA=0; err_count=0; every memory word cleared to 0.
- All outputs come from registers. There is no combinational path from any input to any output.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE to SETUP when PSELx=1 and PENABLE=0.
  - SETUP to ACCESS on the next edge if PSELx=1 and PENABLE=1; otherwise back to IDLE with no side effects.
  - At the SETUP to ACCESS edge: latch PADDR, PWRITE, PPROT, PWDATA, PSTRB and cfg_wait; evaluate the checks below; load wcnt=cfg_wait.
  - In ACCESS: while wcnt>0, hold PREADY=0 and decrement each cycle.
  - PREADY=1 for exactly one cycle, the first ACCESS cycle with wcnt=0. With cfg_wait=0 PREADY is high in the first ACCESS cycle; with cfg_wait=N it is high in ACCESS cycle N+1.
  - After the PREADY cycle: go to SETUP if PSELx=1 and PENABLE=0 (back-to-back transfer); otherwise go to IDLE.
- Abort: if PSELx or PENABLE drops while in ACCESS before PREADY, go to IDLE, clear the outputs, make no memory write and do not increment err_count.
- Mid-transfer input changes: changes to address, data or control during ACCESS are ignored; the values latched at the SETUP to ACCESS edge are used.
- Checks, evaluated on latched values; any failure gives PSLVERR=1 in the PREADY cycle:
  - Unaligned: PADDR[log2(STRB_WIDTH)-1:0] != 0.
  - Region index r = word_addr[log2(DEPTH)-1 -: log2(NUM_REGIONS)].
  - Privilege: PRIV_MASK[r]=1 and PPROT[0]=0.
  - Security: SECURE_MASK[r]=1 and PPROT[1]=1.
  - Read strobes: a read with PSTRB != 0.
- Write, no error: memory word updated on the PREADY edge, bytes gated by PSTRB. PSTRB=0 is a no-op write with an OKAY response.
- Read, no error: PRDATA = mem[word_addr], presented in the PREADY cycle. The memory value is sampled at the SETUP to ACCESS edge.
- Errored transfer: no memory update; PRDATA=0; err_count increments on the PREADY edge and saturates at 16'hFFFF.
- Outside the PREADY cycle, PRDATA and PSLVERR are 0.
- PPROT[2] (data/instruction) is ignored.
- Reset asserted mid-transfer: everything returns immediately to reset values; a pending write is discarded.

Decomposition:
- Shared package apb_mem_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS);
  - the localparams for word-index and region-index widths;
  - the check-result struct {unaligned, priv_fail, sec_fail, strb_fail}.
- One sub-module, apb_access_check: purely combinational. Takes the latched address, PPROT, PWRITE and PSTRB; returns the check struct and the word index.

Test Plan (defaults: DATA_WIDTH=32, ADDR_WIDTH=10):
1. Write 0xDEADBEEF to 0x004, PSTRB=4'hF, PPROT=3'b000, cfg_wait=0 -> PREADY high in the first ACCESS cycle, PSLVERR=0. Then read 0x004 with PSTRB=0 -> PRDATA=0xDEADBEEF.
2. cfg_wait=3, write 0x11223344 to 0x008 with PSTRB=4'b0101, over existing word 0 -> PREADY rises in the 4th ACCESS cycle. A later read returns 0x00220044.
3. Write to 0x200 (region 4) with PPROT=3'b000 -> PSLVERR=1, memory unchanged, err_count=1. Repeat with PPROT=3'b001 -> OKAY.
4. Read 0x3FC (region 7) with PPROT=3'b011 -> PSLVERR=1. Read 0x006 (unaligned) -> PSLVERR=1. Read with PSTRB=4'h1 -> PSLVERR=1. After these, err_count has risen by 3.
5. cfg_wait=5, drop PENABLE in the 2nd ACCESS cycle of a write to 0x010 -> FSM returns to IDLE, PREADY never asserts, word at 0x010 unchanged, err_count unchanged.
6. Pull PRESETn low during the wait states of a write to 0x020 -> outputs go to 0 immediately, memory cleared. A subsequent back-to-back write then read of 0x020 (SETUP directly after the PREADY cycle) completes correctly.
